// File: rtl/wb_queue_pkg.sv
// Shared register-file constants and types for the writeback queue slice.
package wb_queue_pkg;
    localparam int REG_BUS_W = 32;
    localparam int REG_AW    = 5;
    localparam int REG_NUM   = 32;

    typedef logic [REG_BUS_W-1:0] reg_bus_t;

    localparam reg_bus_t ZeroWord  = '0;
    localparam logic     RstEnable = 1'b0;
endpackage

// File: rtl/wb_queue_if.sv
// EX writeback, ID operand read and register-file port bundle for wb_queue.
interface wb_queue_if
    import wb_queue_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = REG_AW
) ();
    logic                 ex_wr_valid_i;
    logic                 ex_wr_ready_o;
    logic [AW-1:0]        ex_rd_i;
    logic [DW-1:0]        ex_rd_data_i;
    logic                 id_rs1_valid_i;
    logic                 id_rs2_valid_i;
    logic [AW-1:0]        id_rs1_i;
    logic [AW-1:0]        id_rs2_i;
    logic [DW-1:0]        id_rs1_data_o;
    logic [DW-1:0]        id_rs2_data_o;
    logic                 id_stall_o;
    logic [REG_BUS_W-1:0] rf_rs1_o;
    logic [REG_BUS_W-1:0] rf_rs2_o;
    logic                 rf_rs1_rd_valid_o;
    logic                 rf_rs2_rd_valid_o;
    logic [DW-1:0]        rf_rs1_data_i;
    logic [DW-1:0]        rf_rs2_data_i;
    logic [REG_BUS_W-1:0] rf_rd_o;
    logic [DW-1:0]        rf_rd_data_o;
    logic                 rf_rd_wr_valid_o;

    modport master (
        input  ex_wr_valid_i, ex_rd_i, ex_rd_data_i,
               id_rs1_valid_i, id_rs2_valid_i, id_rs1_i, id_rs2_i,
               rf_rs1_data_i, rf_rs2_data_i,
        output ex_wr_ready_o, id_rs1_data_o, id_rs2_data_o, id_stall_o,
               rf_rs1_o, rf_rs2_o, rf_rs1_rd_valid_o, rf_rs2_rd_valid_o,
               rf_rd_o, rf_rd_data_o, rf_rd_wr_valid_o
    );

    modport slave (
        output ex_wr_valid_i, ex_rd_i, ex_rd_data_i,
               id_rs1_valid_i, id_rs2_valid_i, id_rs1_i, id_rs2_i,
               rf_rs1_data_i, rf_rs2_data_i,
        input  ex_wr_ready_o, id_rs1_data_o, id_rs2_data_o, id_stall_o,
               rf_rs1_o, rf_rs2_o, rf_rs1_rd_valid_o, rf_rs2_rd_valid_o,
               rf_rd_o, rf_rd_data_o, rf_rd_wr_valid_o
    );
endinterface

// File: rtl/wb_fwd_mux.sv
// Combinational operand forwarding: x0, then in-flight EX write, then youngest
// queued write for the index, else register-file data.
module wb_fwd_mux #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int PW    = 2,
    parameter int CW    = 3
) (
    input  logic [AW-1:0] idx,
    input  logic          ex_hit_en,
    input  logic [AW-1:0] ex_rd,
    input  logic [DW-1:0] ex_data,
    input  logic [AW-1:0] ent_rd   [DEPTH],
    input  logic [DW-1:0] ent_data [DEPTH],
    input  logic [PW-1:0] rptr,
    input  logic [CW-1:0] count,
    input  logic [DW-1:0] rf_data,
    output logic [DW-1:0] data
);
    logic [PW-1:0] slot;

    // Scan oldest to youngest from rptr so the last hit is the youngest entry.
    always_comb begin
        data = rf_data;
        slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rptr + PW'(i);
            if ((CW'(i) < count) && (ent_rd[slot] == idx)) begin
                data = ent_data[slot];
            end
        end
        if (ex_hit_en && (ex_rd == idx)) begin
            data = ex_data;
        end
        if (idx == '0) begin
            data = '0;
        end
    end
endmodule

// File: rtl/wb_queue.sv
// Register-file client: queues EX writebacks, drains them on cycles with no ID
// read (or when full), and forwards pending data to ID operand reads.
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = REG_AW
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_queue_if.master  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] ent_rd   [DEPTH];
    logic [DW-1:0] ent_data [DEPTH];
    logic [PW-1:0] rptr_q, wptr_q;
    logic [CW-1:0] count_q;

    logic          run;
    logic          rdreq;
    logic          full;
    logic          drain;
    logic          ready;
    logic          accept;
    logic          enq;
    logic          stall;
    logic [DW-1:0] fwd1, fwd2;

    always_comb begin
        run    = (rst_n != RstEnable);
        rdreq  = bus.id_rs1_valid_i || bus.id_rs2_valid_i;
        full   = (count_q == CW'(DEPTH));
        drain  = run && (count_q != '0) && (!rdreq || full);
        ready  = !full || drain;
        accept = run && bus.ex_wr_valid_i && ready;
        enq    = accept && (bus.ex_rd_i != '0);
        stall  = rdreq && drain;
    end

    // Storage carries no reset; entries are only observed below count_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_rd[wptr_q]   <= bus.ex_rd_i;
            ent_data[wptr_q] <= bus.ex_rd_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (drain) begin
                rptr_q <= rptr_q + PW'(1);
            end
            count_q <= count_q + CW'(enq) - CW'(drain);
        end
    end

    wb_fwd_mux #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .PW(PW), .CW(CW)) u_fwd_rs1 (
        .idx       (bus.id_rs1_i),
        .ex_hit_en (accept),
        .ex_rd     (bus.ex_rd_i),
        .ex_data   (bus.ex_rd_data_i),
        .ent_rd    (ent_rd),
        .ent_data  (ent_data),
        .rptr      (rptr_q),
        .count     (count_q),
        .rf_data   (bus.rf_rs1_data_i),
        .data      (fwd1)
    );

    wb_fwd_mux #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .PW(PW), .CW(CW)) u_fwd_rs2 (
        .idx       (bus.id_rs2_i),
        .ex_hit_en (accept),
        .ex_rd     (bus.ex_rd_i),
        .ex_data   (bus.ex_rd_data_i),
        .ent_rd    (ent_rd),
        .ent_data  (ent_data),
        .rptr      (rptr_q),
        .count     (count_q),
        .rf_data   (bus.rf_rs2_data_i),
        .data      (fwd2)
    );

    // Index and data outputs are forced to zero while reset is asserted.
    always_comb begin
        bus.ex_wr_ready_o     = ready;
        bus.id_stall_o        = stall;
        bus.rf_rd_wr_valid_o  = drain;
        bus.rf_rd_o           = drain ? REG_BUS_W'(ent_rd[rptr_q]) : ZeroWord;
        bus.rf_rd_data_o      = drain ? ent_data[rptr_q] : '0;
        bus.rf_rs1_rd_valid_o = run && bus.id_rs1_valid_i && !stall;
        bus.rf_rs2_rd_valid_o = run && bus.id_rs2_valid_i && !stall;
        bus.rf_rs1_o          = run ? REG_BUS_W'(bus.id_rs1_i) : ZeroWord;
        bus.rf_rs2_o          = run ? REG_BUS_W'(bus.id_rs2_i) : ZeroWord;
        bus.id_rs1_data_o     = (run && bus.id_rs1_valid_i && !stall) ? fwd1 : '0;
        bus.id_rs2_data_o     = (run && bus.id_rs2_valid_i && !stall) ? fwd2 : '0;
    end
endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue; the register-file model returns the index as data.
module tb_wb_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    wb_queue_if #(.DW(32), .AW(5)) bus ();

    wb_queue #(.DEPTH(4), .DW(32), .AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.rf_rs1_data_i = bus.rf_rs1_o;
    assign bus.rf_rs2_data_i = bus.rf_rs2_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic wv, input logic [4:0] wrd, input logic [31:0] wdat,
                       input logic v1, input logic [4:0] r1,
                       input logic v2, input logic [4:0] r2);
        bus.ex_wr_valid_i  = wv;
        bus.ex_rd_i        = wrd;
        bus.ex_rd_data_i   = wdat;
        bus.id_rs1_valid_i = v1;
        bus.id_rs1_i       = r1;
        bus.id_rs2_valid_i = v2;
        bus.id_rs2_i       = r2;
    endtask

    always @(negedge clk) begin
        chk("count_bound", {31'b0, (dut.count_q <= 3'd4)}, 32'd1);
    end

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0);
        #2;
        // Reset state, with live-looking inputs that must not leak through
        drv(1, 3, 32'h1234, 1, 5, 0, 0);
        #1;
        chk("rst_ready",    bus.ex_wr_ready_o, 1);
        chk("rst_wr_valid", bus.rf_rd_wr_valid_o, 0);
        chk("rst_stall",    bus.id_stall_o, 0);
        chk("rst_rs1_rdv",  bus.rf_rs1_rd_valid_o, 0);
        chk("rst_rs1_idx",  bus.rf_rs1_o, 0);
        chk("rst_rs1_data", bus.id_rs1_data_o, 0);
        chk("rst_count",    dut.count_q, 0);

        @(negedge clk);
        rst_n = 1'b1;
        drv(0, 0, 0, 1, 5, 0, 0);
        #1;
        chk("idle_rs1_data", bus.id_rs1_data_o, 32'h5);
        chk("idle_rs1_rdv",  bus.rf_rs1_rd_valid_o, 1);
        chk("idle_rs1_idx",  bus.rf_rs1_o, 5);
        chk("idle_wr_valid", bus.rf_rd_wr_valid_o, 0);
        chk("idle_rs2_rdv",  bus.rf_rs2_rd_valid_o, 0);

        @(negedge clk);
        drv(1, 3, 32'hDEAD, 0, 0, 0, 0);
        #1;
        chk("x3_ready",    bus.ex_wr_ready_o, 1);
        chk("x3_no_wr",    bus.rf_rd_wr_valid_o, 0);

        @(negedge clk);
        drv(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("x3_wr_valid", bus.rf_rd_wr_valid_o, 1);
        chk("x3_wr_idx",   bus.rf_rd_o, 3);
        chk("x3_wr_data",  bus.rf_rd_data_o, 32'hDEAD);

        @(negedge clk);
        #1;
        chk("x3_done_wr",  bus.rf_rd_wr_valid_o, 0);
        chk("x3_empty",    dut.count_q, 0);

        // Writes under continuous reads: nothing drains
        @(negedge clk);
        drv(1, 7, 32'h11, 1, 7, 1, 3);
        #1;
        chk("x7a_inflight", bus.id_rs1_data_o, 32'h11);
        chk("x7a_rs2_rf",   bus.id_rs2_data_o, 32'h3);
        chk("x7a_no_wr",    bus.rf_rd_wr_valid_o, 0);
        chk("x7a_stall",    bus.id_stall_o, 0);

        @(negedge clk);
        drv(1, 7, 32'h22, 1, 7, 1, 3);
        #1;
        chk("x7b_inflight", bus.id_rs1_data_o, 32'h22);
        chk("x7b_count",    dut.count_q, 1);
        chk("x7b_no_wr",    bus.rf_rd_wr_valid_o, 0);

        @(negedge clk);
        drv(1, 9, 32'h99, 1, 7, 1, 0);
        #1;
        chk("x7_youngest",  bus.id_rs1_data_o, 32'h22);
        chk("rs2_x0",       bus.id_rs2_data_o, 0);
        chk("fill_count2",  dut.count_q, 2);
        chk("fill_no_wr2",  bus.rf_rd_wr_valid_o, 0);

        @(negedge clk);
        drv(1, 10, 32'hAA, 1, 9, 0, 0);
        #1;
        chk("x9_fwd",       bus.id_rs1_data_o, 32'h99);
        chk("fill_count3",  dut.count_q, 3);

        // Full: the write wins, ID stalls, fifth offer still accepted
        @(negedge clk);
        drv(1, 11, 32'hBB, 1, 7, 0, 0);
        #1;
        chk("full_count",   dut.count_q, 4);
        chk("full_ready",   bus.ex_wr_ready_o, 1);
        chk("full_stall",   bus.id_stall_o, 1);
        chk("full_wr_v",    bus.rf_rd_wr_valid_o, 1);
        chk("full_wr_idx",  bus.rf_rd_o, 7);
        chk("full_wr_data", bus.rf_rd_data_o, 32'h11);
        chk("full_rs1_rdv", bus.rf_rs1_rd_valid_o, 0);
        chk("full_rs1_dat", bus.id_rs1_data_o, 0);

        @(negedge clk);
        drv(0, 0, 0, 1, 7, 0, 0);
        #1;
        chk("full2_count",  dut.count_q, 4);
        chk("full2_stall",  bus.id_stall_o, 1);
        chk("full2_wr_idx", bus.rf_rd_o, 7);
        chk("full2_wr_dat", bus.rf_rd_data_o, 32'h22);

        @(negedge clk);
        drv(0, 0, 0, 1, 11, 1, 9);
        #1;
        chk("wrap_count",   dut.count_q, 3);
        chk("wrap_stall",   bus.id_stall_o, 0);
        chk("wrap_no_wr",   bus.rf_rd_wr_valid_o, 0);
        chk("wrap_rs1",     bus.id_rs1_data_o, 32'hBB);
        chk("wrap_rs2",     bus.id_rs2_data_o, 32'h99);
        chk("wrap_rs1_rdv", bus.rf_rs1_rd_valid_o, 1);

        // x0 write is accepted but dropped; x0 read is always zero
        @(negedge clk);
        drv(1, 0, 32'hFFFF, 1, 0, 1, 10);
        #1;
        chk("x0_rs1",       bus.id_rs1_data_o, 0);
        chk("x0_rs2_fwd",   bus.id_rs2_data_o, 32'hAA);
        chk("x0_ready",     bus.ex_wr_ready_o, 1);

        @(negedge clk);
        drv(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("x0_dropped",   dut.count_q, 3);
        chk("drain_v",      bus.rf_rd_wr_valid_o, 1);
        chk("drain_idx",    bus.rf_rd_o, 9);
        chk("drain_data",   bus.rf_rd_data_o, 32'h99);

        @(negedge clk);
        drv(1, 12, 32'hCC, 1, 10, 0, 0);
        #1;
        chk("m2_count",     dut.count_q, 2);
        chk("m2_rs1",       bus.id_rs1_data_o, 32'hAA);

        @(negedge clk);
        drv(0, 0, 0, 1, 12, 0, 0);
        #1;
        chk("m3_count",     dut.count_q, 3);
        chk("m3_rs1",       bus.id_rs1_data_o, 32'hCC);

        // Reset mid-cycle with three entries pending
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_count",   dut.count_q, 0);
        chk("mrst_wr_v",    bus.rf_rd_wr_valid_o, 0);
        chk("mrst_ready",   bus.ex_wr_ready_o, 1);
        chk("mrst_rs1",     bus.id_rs1_data_o, 0);

        @(negedge clk);
        rst_n = 1'b1;
        drv(0, 0, 0, 1, 11, 1, 12);
        #1;
        chk("post_rs1_rf",  bus.id_rs1_data_o, 32'd11);
        chk("post_rs2_rf",  bus.id_rs2_data_o, 32'd12);
        chk("post_count",   dut.count_q, 0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drv(0, 0, 0, 0, 0, 0, 0);
            #1;
            chk("post_no_wr",  bus.rf_rd_wr_valid_o, 0);
        end

        @(negedge clk);
        drv(1, 0, 32'hFFFF, 0, 0, 0, 0);
        #1;
        chk("x0i_ready",    bus.ex_wr_ready_o, 1);

        @(negedge clk);
        drv(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("x0i_no_wr",    bus.rf_rd_wr_valid_o, 0);
        chk("x0i_count",    dut.count_q, 0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
